exu_alu_pipe: RTL and testbench

EXU_ALU_PIPE -- requirements
Module: exu_alu_pipe

---
 rtl/exu_alu_pkg.sv | 25 ++
 rtl/exu_alu_core.sv | 76 +++++++
 rtl/exu_alu_pipe.sv | 103 ++++++++++
 tb/tb_exu_alu_pipe.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_alu_pkg.sv
// Shared ALU constants: one-hot opcode bit positions, opcode width and word-mode encoding.
package exu_alu_pkg;

   localparam int unsigned AluOpWidth = 14;

   typedef enum logic [3:0] {
      AluAdd  = 4'd0,
      AluSub  = 4'd1,
      AluSlt  = 4'd2,
      AluSltu = 4'd3,
      AluNor  = 4'd4,
      AluAnd  = 4'd5,
      AluOr   = 4'd6,
      AluXor  = 4'd7,
      AluOrn  = 4'd8,
      AluAndn = 4'd9,
      AluSll  = 4'd10,
      AluSrl  = 4'd11,
      AluSra  = 4'd12,
      AluLui  = 4'd13
   } alu_op_idx_e;

   localparam logic WordMode = 1'b1;

endpackage

// File: rtl/exu_alu_core.sv
// Combinational ALU datapath: one-hot opcode decode, add/sub, compares, logic ops, shifts, lui.
module exu_alu_core
   import exu_alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned ALU_OP_WIDTH = AluOpWidth
) (
   input  logic [ALU_OP_WIDTH-1:0] op_i,
   input  logic                    word_i,
   input  logic [DATA_WIDTH-1:0]   src1_i,
   input  logic [DATA_WIDTH-1:0]   src2_i,
   output logic [DATA_WIDTH-1:0]   result_o,
   output logic                    illegal_o
);

   localparam int unsigned ShW = $clog2(DATA_WIDTH);

   logic                  word;
   logic                  legal;
   logic                  is_sub;
   logic                  lt_s;
   logic                  lt_u;
   logic [DATA_WIDTH-1:0] sum;
   logic [4:0]            sh_w;
   logic [ShW-1:0]        sh_d;
   logic [31:0]           sll_w;
   logic [31:0]           srl_w;
   logic [31:0]           sra_w;

   function automatic logic [DATA_WIDTH-1:0] sext32(input logic [31:0] v);
      return DATA_WIDTH'($signed(v));
   endfunction

   // Word mode only exists on the 64-bit datapath.
   assign word   = (word_i == WordMode) && (DATA_WIDTH == 64);
   assign legal  = (op_i != '0) && ((op_i & (op_i - ALU_OP_WIDTH'(1))) == '0);
   assign is_sub = op_i[AluSub];

   assign sum  = src1_i + (is_sub ? ~src2_i : src2_i) + DATA_WIDTH'(is_sub);
   assign sh_w = src2_i[4:0];
   assign sh_d = src2_i[ShW-1:0];

   assign sll_w = src1_i[31:0] << sh_w;
   assign srl_w = src1_i[31:0] >> sh_w;
   assign sra_w = $unsigned($signed(src1_i[31:0]) >>> sh_w);

   assign lt_s = word ? ($signed(src1_i[31:0]) < $signed(src2_i[31:0]))
                      : ($signed(src1_i) < $signed(src2_i));
   assign lt_u = word ? (src1_i[31:0] < src2_i[31:0]) : (src1_i < src2_i);

   always_comb begin
      result_o = '0;
      if (legal) begin
         unique case (1'b1)
            op_i[AluAdd], op_i[AluSub]: result_o = word ? sext32(sum[31:0]) : sum;
            op_i[AluSlt]:  result_o = DATA_WIDTH'(lt_s);
            op_i[AluSltu]: result_o = DATA_WIDTH'(lt_u);
            op_i[AluNor]:  result_o = ~(src1_i | src2_i);
            op_i[AluAnd]:  result_o = src1_i & src2_i;
            op_i[AluOr]:   result_o = src1_i | src2_i;
            op_i[AluXor]:  result_o = src1_i ^ src2_i;
            op_i[AluOrn]:  result_o = src1_i | ~src2_i;
            op_i[AluAndn]: result_o = src1_i & ~src2_i;
            op_i[AluSll]:  result_o = word ? sext32(sll_w) : (src1_i << sh_d);
            op_i[AluSrl]:  result_o = word ? sext32(srl_w) : (src1_i >> sh_d);
            op_i[AluSra]:  result_o = word ? sext32(sra_w)
                                           : $unsigned($signed(src1_i) >>> sh_d);
            op_i[AluLui]:  result_o = src2_i;
            default:       result_o = '0;
         endcase
      end
   end

   assign illegal_o = !legal;

endmodule

// File: rtl/exu_alu_pipe.sv
// Two-stage ALU pipeline: S1 holds the accepted request, S2 holds the computed result.
module exu_alu_pipe
   import exu_alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned TAG_WIDTH    = 6,
   parameter int unsigned ALU_OP_WIDTH = AluOpWidth
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ALU_OP_WIDTH-1:0] in_op,
   input  logic                    in_word,
   input  logic [DATA_WIDTH-1:0]   in_src1,
   input  logic [DATA_WIDTH-1:0]   in_src2,
   input  logic [TAG_WIDTH-1:0]    in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_result,
   output logic [TAG_WIDTH-1:0]    out_tag,
   output logic                    out_illegal
);

   logic                    s1_valid_q;
   logic [ALU_OP_WIDTH-1:0] s1_op_q;
   logic                    s1_word_q;
   logic [DATA_WIDTH-1:0]   s1_src1_q;
   logic [DATA_WIDTH-1:0]   s1_src2_q;
   logic [TAG_WIDTH-1:0]    s1_tag_q;

   logic                    s2_valid_q;
   logic [DATA_WIDTH-1:0]   s2_result_q;
   logic [TAG_WIDTH-1:0]    s2_tag_q;
   logic                    s2_illegal_q;

   logic                    s2_advance;
   logic                    s1_advance;
   logic                    accept;
   logic [DATA_WIDTH-1:0]   core_result;
   logic                    core_illegal;

   assign s2_advance = !s2_valid_q || out_ready;
   assign s1_advance = s1_valid_q && s2_advance;
   assign in_ready   = !s1_valid_q || s1_advance;
   assign accept     = in_valid && in_ready;

   exu_alu_core #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ALU_OP_WIDTH(ALU_OP_WIDTH)
   ) u_core (
      .op_i     (s1_op_q),
      .word_i   (s1_word_q),
      .src1_i   (s1_src1_q),
      .src2_i   (s1_src2_q),
      .result_o (core_result),
      .illegal_o(core_illegal)
   );

   // Valid bits and output registers; reset beats flush, flush beats every handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_result_q  <= '0;
         s2_tag_q     <= '0;
         s2_illegal_q <= 1'b0;
      end else if (flush) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         if (s2_advance) begin
            s2_valid_q <= s1_valid_q;
         end
         if (s1_advance) begin
            s2_result_q  <= core_result;
            s2_tag_q     <= s1_tag_q;
            s2_illegal_q <= core_illegal;
         end
         if (in_ready) begin
            s1_valid_q <= in_valid;
         end
      end
   end

   // S1 payload is qualified by s1_valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_op_q   <= in_op;
         s1_word_q <= in_word;
         s1_src1_q <= in_src1;
         s1_src2_q <= in_src2;
         s1_tag_q  <= in_tag;
      end
   end

   assign out_valid   = s2_valid_q;
   assign out_result  = s2_result_q;
   assign out_tag     = s2_tag_q;
   assign out_illegal = s2_illegal_q;

endmodule

// File: tb/tb_exu_alu_pipe.sv
// Bench for exu_alu_pipe: directed vector table, corner-case sequences, randomized scoreboard.
module tb_exu_alu_pipe;

   localparam int DW = 64;
   localparam int TW = 6;
   localparam int OW = 14;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [OW-1:0] in_op;
   logic          in_word;
   logic [DW-1:0] in_src1;
   logic [DW-1:0] in_src2;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_result;
   logic [TW-1:0] out_tag;
   logic          out_illegal;

   always #5 clk = ~clk;

   exu_alu_pipe #(
      .DATA_WIDTH  (DW),
      .TAG_WIDTH   (TW),
      .ALU_OP_WIDTH(OW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_word    (in_word),
      .in_src1    (in_src1),
      .in_src2    (in_src2),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag),
      .out_illegal(out_illegal)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] sx(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // Reference ALU: returns {illegal, result}.
   function automatic logic [64:0] model_alu(input logic [13:0] op, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
      logic [63:0] r;
      logic [31:0] a32;
      logic [31:0] b32;
      int          idx;
      int          n;
      a32 = a[31:0];
      b32 = b[31:0];
      if ($countones(op) != 1) return {1'b1, 64'd0};
      idx = 0;
      for (int i = 0; i < 14; i++) if (op[i]) idx = i;
      n = w ? int'(b[4:0]) : int'(b[5:0]);
      case (idx)
         0:  r = w ? sx(a32 + b32) : a + b;
         1:  r = w ? sx(a32 - b32) : a - b;
         2:  r = w ? {63'd0, $signed(a32) < $signed(b32)} : {63'd0, $signed(a) < $signed(b)};
         3:  r = w ? {63'd0, a32 < b32} : {63'd0, a < b};
         4:  r = ~(a | b);
         5:  r = a & b;
         6:  r = a | b;
         7:  r = a ^ b;
         8:  r = a | ~b;
         9:  r = a & ~b;
         10: r = w ? sx(a32 << n) : a << n;
         11: r = w ? sx(a32 >> n) : a >> n;
         12: r = w ? sx((a32 >> n) | (a32[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0))
                   : ((a >> n) | (a[63] ? ~(64'hFFFF_FFFF_FFFF_FFFF >> n) : 64'd0));
         13: r = b;
         default: r = 64'd0;
      endcase
      return {1'b0, r};
   endfunction

   typedef struct {
      logic [13:0] op;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      logic [5:0]  tag;
      logic [63:0] exp;
      logic        ill;
   } vec_t;

   typedef struct {
      logic [63:0] res;
      logic [5:0]  tag;
      logic        ill;
   } exp_t;

   vec_t vecs[9];
   exp_t sb[$];
   int   got[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      flush    = 1'b0;
      in_op    = '0;
      in_word  = 1'b0;
      in_src1  = '0;
      in_src2  = '0;
      in_tag   = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [64:0] m;
      logic        hold;
      logic [63:0] hold_res;
      logic [5:0]  hold_tag;
      logic        hold_ill;
      int          fires;
      int          tag_next;
      int          tag_at2;

      vecs[0] = '{14'h0001, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd1, 6'd10,
                  64'hFFFF_FFFF_8000_0000, 1'b0};
      vecs[1] = '{14'h1000, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 6'd11,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[2] = '{14'h0800, 1'b1, 64'h0000_0000_8000_0000, 64'd4, 6'd12,
                  64'h0000_0000_0800_0000, 1'b0};
      vecs[3] = '{14'h0004, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd13, 64'd1, 1'b0};
      vecs[4] = '{14'h0008, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd14, 64'd0, 1'b0};
      vecs[5] = '{14'h0003, 1'b0, 64'd7, 64'd9, 6'd5, 64'd0, 1'b1};
      vecs[6] = '{14'h2000, 1'b0, 64'h1234, 64'hDEAD_BEEF_CAFE_F00D, 6'd15,
                  64'hDEAD_BEEF_CAFE_F00D, 1'b0};
      vecs[7] = '{14'h0002, 1'b0, 64'd5, 64'd7, 6'd16, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
      vecs[8] = '{14'h0000, 1'b0, 64'd1, 64'd2, 6'd17, 64'd0, 1'b1};

      // Reset with a request presented: it must be dropped.
      idle();
      rst       = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_op     = 14'h0001;
      in_tag    = 6'd33;
      repeat (3) step();
      chk("reset out_valid", out_valid, 0);
      chk("reset in_ready", in_ready, 1);
      chk("reset out_result", out_result, 0);
      chk("reset out_tag", out_tag, 0);
      chk("reset out_illegal", out_illegal, 0);
      rst = 1'b0;
      idle();
      #1;
      chk("post-reset in_ready", in_ready, 1);
      step();
      step();
      chk("reset request dropped", out_valid, 0);

      // Directed table: latency and value of each vector on an empty pipeline.
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_op    = vecs[i].op;
         in_word  = vecs[i].w;
         in_src1  = vecs[i].a;
         in_src2  = vecs[i].b;
         in_tag   = vecs[i].tag;
         #1;
         chk($sformatf("vec%0d in_ready", i), in_ready, 1);
         step();
         idle();
         #1;
         chk($sformatf("vec%0d out_valid early", i), out_valid, 0);
         step();
         chk($sformatf("vec%0d out_valid", i), out_valid, 1);
         chk($sformatf("vec%0d result", i), out_result, vecs[i].exp);
         chk($sformatf("vec%0d tag", i), out_tag, vecs[i].tag);
         chk($sformatf("vec%0d illegal", i), out_illegal, vecs[i].ill);
         step();
      end

      // Back-pressure: tags 1..4 back to back, out_ready low while the first result waits.
      tag_next = 1;
      tag_at2  = 0;
      got.delete();
      for (int c = 0; c < 20; c++) begin
         out_ready = (c >= 5);
         in_valid  = (tag_next <= 4);
         in_op     = 14'h0001;
         in_word   = 1'b0;
         in_src1   = 64'(tag_next);
         in_src2   = 64'(tag_next * 16);
         in_tag    = 6'(tag_next);
         #1;
         if (c == 2) tag_at2 = tag_next;
         if (c >= 2 && c <= 4) begin
            chk($sformatf("bp in_ready c%0d", c), in_ready, 0);
            chk($sformatf("bp out_valid c%0d", c), out_valid, 1);
            chk($sformatf("bp out_tag c%0d", c), out_tag, 1);
            chk($sformatf("bp out_result c%0d", c), out_result, 17);
         end
         if (in_valid && in_ready) tag_next++;
         if (out_valid && out_ready) got.push_back(int'(out_tag));
         step();
      end
      idle();
      chk("bp accepts before stall", tag_at2, 3);
      chk("bp output count", got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++)
         chk($sformatf("bp order %0d", i), got[i], i + 1);

      // Flush with both stages full and a third request presented.
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         in_op    = 14'h0020;
         in_src1  = 64'hFF;
         in_src2  = 64'h0F;
         in_tag   = 6'(11 + c);
         flush    = (c == 2);
         step();
      end
      idle();
      #1;
      chk("flush out_valid", out_valid, 0);
      chk("flush in_ready", in_ready, 1);
      out_ready = 1'b1;
      fires = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (out_valid) fires++;
         step();
      end
      chk("flush no results", fires, 0);

      // Flush on an empty pipeline drops the request presented with it.
      in_valid = 1'b1;
      in_op    = 14'h0001;
      in_tag   = 6'd14;
      flush    = 1'b1;
      step();
      idle();
      fires = 0;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (out_valid) fires++;
         step();
      end
      chk("flush drops new request", fires, 0);

      // Reset mid-stream.
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         in_op    = 14'h0001;
         in_src1  = 64'd3;
         in_src2  = 64'd4;
         in_tag   = 6'(20 + c);
         rst      = (c == 2);
         step();
      end
      idle();
      #1;
      chk("rst mid out_valid", out_valid, 0);
      chk("rst mid in_ready", in_ready, 1);
      chk("rst mid out_tag", out_tag, 0);
      rst = 1'b0;
      #1;
      chk("rst mid in_ready after", in_ready, 1);
      fires = 0;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (out_valid) fires++;
         step();
      end
      chk("rst mid no results", fires, 0);

      // Randomized traffic against the reference model.
      sb.delete();
      hold = 1'b0;
      hold_res = '0;
      hold_tag = '0;
      hold_ill = 1'b0;
      for (int c = 0; c < 900; c++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         if ($urandom_range(9) == 0) in_op = 14'($urandom);
         else in_op = 14'(1) << $urandom_range(13);
         in_word = 1'($urandom);
         in_src1 = {$urandom, $urandom};
         in_src2 = ($urandom_range(3) == 0) ? 64'($urandom_range(70)) : {$urandom, $urandom};
         if ($urandom_range(7) == 0) in_src1 = 64'h8000_0000_8000_0000;
         in_tag = 6'($urandom);
         #1;
         if (hold) begin
            chk("stall out_valid", out_valid, 1);
            chk("stall out_result", out_result, hold_res);
            chk("stall out_tag", out_tag, hold_tag);
            chk("stall out_illegal", out_illegal, hold_ill);
         end
         hold     = out_valid && !out_ready;
         hold_res = out_result;
         hold_tag = out_tag;
         hold_ill = out_illegal;
         if (in_valid && in_ready) begin
            m = model_alu(in_op, in_word, in_src1, in_src2);
            sb.push_back('{m[63:0], in_tag, m[64]});
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("rand unexpected output", 1, 0);
            end else begin
               chk("rand result", out_result, sb[0].res);
               chk("rand tag", out_tag, sb[0].tag);
               chk("rand illegal", out_illegal, sb[0].ill);
               void'(sb.pop_front());
            end
         end
         step();
      end
      idle();
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("drain unexpected output", 1, 0);
            end else begin
               chk("drain result", out_result, sb[0].res);
               chk("drain tag", out_tag, sb[0].tag);
               void'(sb.pop_front());
            end
         end
         step();
      end
      chk("rand scoreboard empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
